// File: rtl/rgb_command_receiver_if.sv
// rgb_command_receiver_if: serial command line in, decoded LED mode and link status out
interface rgb_command_receiver_if;
  logic       UART_RX;
  logic [7:0] RPM_RGB;
  logic       CMD_VALID;
  logic       LINK_LOST;
  logic [7:0] FRAME_ERR_CNT;
  modport master(output UART_RX, input RPM_RGB, CMD_VALID, LINK_LOST, FRAME_ERR_CNT);
  modport slave(input UART_RX, output RPM_RGB, CMD_VALID, LINK_LOST, FRAME_ERR_CNT);
endinterface

// File: rtl/rgb_command_receiver.sv
// rgb_command_receiver: UART 8N1 receiver, 3-byte frame validator and link watchdog driving the RGB mode
module rgb_command_receiver #(
  parameter int         CLKS_PER_BIT   = 434,
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0] DEFAULT_MODE   = 8'd0,
  parameter logic [7:0] TIMEOUT_MODE   = 8'd1,
  parameter logic [7:0] HEADER         = 8'hA5
) (
  input logic FPGA_CLK1_50,
  input logic RST,
  rgb_command_receiver_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int IBT  = 20 * CLKS_PER_BIT;
  localparam int IW   = $clog2(IBT);
  localparam int WW   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
  typedef enum logic [1:0] {WAIT_HDR, WAIT_MODE, WAIT_CHK} pState_t;

  logic rxMeta, rxSync, rxPrev;
  rxState_t rxState, rxNext;
  logic [BW-1:0] bitCnt;
  logic [2:0] bitIdx;
  logic [7:0] byteData;
  logic byteStb, frameErr, halfHit, fullHit;
  pState_t pState, pNext;
  logic [IW-1:0] ibCnt;
  logic [7:0] candMode;
  logic chkByte, frameOk, chkErr, ibExpire;
  logic [WW-1:0] wdCnt;
  logic [7:0] rpmRgb, errCnt;
  logic cmdValid, linkLost;

  assign halfHit  = bitCnt == BW'(HALF - 1);
  assign fullHit  = bitCnt == BW'(CLKS_PER_BIT - 1);
  assign ibExpire = ibCnt == IW'(IBT - 1);

  // Two-stage synchronizer plus delayed copy for falling-edge detection; resets to idle-high so no false start
  always_ff @(posedge FPGA_CLK1_50) begin
    if (RST) {rxMeta, rxSync, rxPrev} <= 3'b111;
    else {rxMeta, rxSync, rxPrev} <= {bus.UART_RX, rxMeta, rxSync};
  end

  // RX next state: start edge, mid-bit glitch rejection, 8 data bits, stop bit
  always_comb begin
    rxNext = rxState;
    case (rxState)
      IDLE:  rxNext = (rxPrev && !rxSync) ? START : IDLE;
      START: rxNext = halfHit ? (rxSync ? IDLE : DATA) : START;
      DATA:  rxNext = (fullHit && bitIdx == 3'd7) ? STOP : DATA;
      STOP:  rxNext = fullHit ? IDLE : STOP;
      default: rxNext = IDLE;
    endcase
  end

  // RX datapath: bit timing, LSB-first shift, registered byte strobe and framing-error pulse
  always_ff @(posedge FPGA_CLK1_50) begin
    if (RST) begin
      rxState  <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      byteData <= '0;
      byteStb  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxState  <= rxNext;
      bitCnt   <= (rxState == IDLE || rxNext != rxState || fullHit) ? '0 : bitCnt + 1'b1;
      byteStb  <= rxState == STOP && fullHit && rxSync;
      frameErr <= rxState == STOP && fullHit && !rxSync;
      if (rxState == IDLE) bitIdx <= '0;
      if (rxState == DATA && fullHit) begin
        byteData <= {rxSync, byteData[7:1]};
        bitIdx   <= bitIdx + 3'd1;
      end
    end
  end

  // Parser next state: header hunt, mode capture, checksum; framing errors and inter-byte silence restart the hunt
  always_comb begin
    chkByte = byteStb && pState == WAIT_CHK;
    frameOk = chkByte && byteData == (HEADER ^ candMode);
    chkErr  = chkByte && !frameOk;
    pNext   = pState;
    if (frameErr || (pState != WAIT_HDR && ibExpire && !byteStb)) pNext = WAIT_HDR;
    else if (byteStb)
      pNext = pState == WAIT_HDR ? (byteData == HEADER ? WAIT_MODE : WAIT_HDR) :
              pState == WAIT_MODE ? WAIT_CHK : WAIT_HDR;
  end

  // Parser state, candidate mode latch and inter-byte timer
  always_ff @(posedge FPGA_CLK1_50) begin
    if (RST) begin
      pState   <= WAIT_HDR;
      candMode <= '0;
      ibCnt    <= '0;
    end else begin
      pState   <= pNext;
      candMode <= (byteStb && pState == WAIT_MODE) ? byteData : candMode;
      ibCnt    <= (pState == WAIT_HDR || byteStb || ibExpire) ? '0 : ibCnt + 1'b1;
    end
  end

  // Outputs: a valid frame beats a simultaneous watchdog expiry; the watchdog holds at its limit until the next frame
  always_ff @(posedge FPGA_CLK1_50) begin
    if (RST) begin
      rpmRgb   <= DEFAULT_MODE;
      cmdValid <= 1'b0;
      linkLost <= 1'b0;
      wdCnt    <= '0;
      errCnt   <= '0;
    end else begin
      cmdValid <= frameOk;
      errCnt   <= ((frameErr || chkErr) && errCnt != 8'hFF) ? errCnt + 8'd1 : errCnt;
      if (frameOk) begin
        rpmRgb   <= candMode;
        linkLost <= 1'b0;
        wdCnt    <= '0;
      end else if (wdCnt == WW'(TIMEOUT_CYCLES - 1)) begin
        rpmRgb   <= TIMEOUT_MODE;
        linkLost <= 1'b1;
      end else wdCnt <= wdCnt + 1'b1;
    end
  end

  assign bus.RPM_RGB       = rpmRgb;
  assign bus.CMD_VALID     = cmdValid;
  assign bus.LINK_LOST     = linkLost;
  assign bus.FRAME_ERR_CNT = errCnt;
endmodule

// File: doc/rgb_command_receiver.md
# rgb_command_receiver

Receives LED-mode commands from the base station over a UART line, validates each 3-byte frame and holds the decoded mode on `RPM_RGB` for the RGB control stage. A link watchdog forces a fault mode when valid frames stop arriving, so a lost link shows as red on the indicator. The block sits between the base-station serial pin and the RGB mode input, in the `FPGA_CLK1_50` domain.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200 baud); must be at least 4.
- `TIMEOUT_CYCLES`, 50_000_000: cycles without a valid frame before the link is declared lost (1 s).
- `DEFAULT_MODE`, 8'd0: `RPM_RGB` value after reset (green).
- `TIMEOUT_MODE`, 8'd1: `RPM_RGB` value forced on link loss (red).
- `HEADER`, 8'hA5: frame start byte.
- `FPGA_CLK1_50`  in  1  system clock, 50 MHz.
- `RST`  in  1  reset; synchronous, active-high.
- `UART_RX`  in  1  asynchronous serial input; idle high, 8N1, LSB first.
- `RPM_RGB`  out  8  registered mode to the RGB stage.
- `CMD_VALID`  out  1  one-cycle pulse when `RPM_RGB` is loaded from a valid frame.
- `LINK_LOST`  out  1  high while the watchdog has expired.
- `FRAME_ERR_CNT`  out  8  saturating count of framing and checksum errors.

## Operation
- **Input synchronizer:** `UART_RX` passes through a 2-FF synchronizer. All logic uses the synchronized value.
- **RX FSM:**
  - IDLE → START on a synchronized high-to-low edge.
  - START waits `CLKS_PER_BIT/2` cycles (integer division) to reach mid-bit. If the line is high there, it is a glitch: return to IDLE with no error. Otherwise go to DATA.
  - DATA samples 8 bits at `CLKS_PER_BIT` intervals, LSB first, then goes to STOP.
  - STOP samples once more after `CLKS_PER_BIT` cycles:
    - High: assert the internal `byte_stb` for one cycle, with `byte_data`.
    - Low: framing error. Increment `FRAME_ERR_CNT`, drop the byte, force the parser to WAIT_HDR.
  - Then return to IDLE.
- **Frame parser FSM:** a frame is `HEADER`, `MODE`, `CHK`, with `CHK = HEADER ^ MODE`.
  - WAIT_HDR: a byte equal to `HEADER` → WAIT_MODE. Any other byte is ignored without error.
  - WAIT_MODE: latch the byte as the candidate mode (any value, including `HEADER`) → WAIT_CHK.
  - WAIT_CHK:
    - Checksum match: load `RPM_RGB` with the candidate, pulse `CMD_VALID`, clear the watchdog and `LINK_LOST`.
    - Mismatch: increment `FRAME_ERR_CNT`, leave `RPM_RGB` unchanged.
    - Either way → WAIT_HDR.
- **Inter-byte timeout:**
  - In WAIT_MODE or WAIT_CHK, if `20*CLKS_PER_BIT` cycles pass without `byte_stb`, the parser returns to WAIT_HDR.
  - This is not counted as an error.
- **Watchdog:**
  - The counter increments every cycle. It is cleared by a valid frame.
  - On reaching `TIMEOUT_CYCLES-1`, load `RPM_RGB <= TIMEOUT_MODE`, set `LINK_LOST`, and hold the counter there until the next valid frame.
- **Error counter:** saturates at 255 and never wraps. If a framing error and a checksum error occur in the same cycle, it increments once.

## Timing
- **Reset values:** `RPM_RGB = DEFAULT_MODE`, `CMD_VALID = 0`, `LINK_LOST = 0`, `FRAME_ERR_CNT = 0`. All FSMs go to IDLE / WAIT_HDR and all counters are cleared.
- **Reset mid-frame:** any partial byte or frame is discarded. The first valid frame after reset release is accepted normally.
- **`byte_stb` timing:** asserts the cycle after the stop-bit sample.
- **Output latency:** `RPM_RGB` and `CMD_VALID` change on the edge following `byte_stb` of the CHK byte, i.e. 2 cycles after the stop-bit sample. `CMD_VALID` lasts exactly one cycle.
- **Input latency:** there is a 2-cycle synchronizer delay from the pin to start detection.
- **Simultaneous events:**
  - Valid frame in the same cycle as watchdog expiry: the frame wins. `RPM_RGB = MODE`, `LINK_LOST = 0`, watchdog = 0.
  - A new start edge may arrive in the cycle after the STOP sample. Back-to-back frames with no idle gap must be received without loss.
- **Repeated frames:** a valid frame carrying the same mode still pulses `CMD_VALID`.

## Test plan
Simulation runs with `CLKS_PER_BIT=8` and `TIMEOUT_CYCLES=2000`.
1. Reset, then send `A5 02 A7` → `RPM_RGB` goes 00→02 2 cycles after the last stop sample; `CMD_VALID` pulses once; `FRAME_ERR_CNT = 0`.
2. Send `A5 01 A5` (bad CHK, expected A4) → `RPM_RGB` unchanged, `FRAME_ERR_CNT = 1`. Then send `A5 01 A4` → `RPM_RGB = 01`.
3. Send a byte with a low stop bit mid-frame, then `A5 00 A5` → `FRAME_ERR_CNT` increments once; `RPM_RGB = 00` after the good frame.
4. After a valid frame, hold the line idle for 2000 cycles → `RPM_RGB = 01` and `LINK_LOST = 1`. A later valid `A5 02 A7` → `RPM_RGB = 02` and `LINK_LOST = 0`.
5. Send `A5`, idle for 200 cycles, then `03 A6` → the frame is rejected. `RPM_RGB` unchanged, no error count, `CMD_VALID` stays low.
6. Stimulus:
   - Send a 1-cycle low glitch on `UART_RX` → no byte is received.
   - Send 300 bad-checksum frames → `FRAME_ERR_CNT` saturates at 255.
   - Assert `RST` mid-byte → all outputs return to their reset values.
